rbb_pp: RTL
===========

# rbb_pp

Multi-bank result batch buffer between a PE array and the host write-request path. The PE array fills one bank while previously committed banks drain line by line to the requester, so compute and write-back overlap. Each batch carries its own line count, so short batches drain only their valid lines.

## Interface
Parameters:
- RBB_ADDR_WIDTH, 8, line-index width; bank depth 2^RBB_ADDR_WIDTH lines
- RBB_DATA_WIDTH, 512, line width in bits
- NUM_BANKS, 2, bank count; power of two, ≥2; BANK_W = clog2(NUM_BANKS)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- WrEn  in  1  write one line into the current fill bank
- WrAddr  in  RBB_ADDR_WIDTH  line index within the fill bank
- WrDin  in  RBB_DATA_WIDTH  line data
- task_done  in  1  single-cycle pulse; commits the fill bank
- task_len  in  RBB_ADDR_WIDTH+1  lines in the batch being committed
- WrBank  out  BANK_W  current fill bank index
- Full  out  1  all banks committed; no fill bank available
- Overflow  out  1  sticky; a write or commit was attempted while Full
- ReqValid  out  1  RdDout/ReqLineIdx/ReqBank valid
- ReqBank  out  BANK_W  bank being drained
- ReqLineIdx  out  RBB_ADDR_WIDTH  line index of RdDout
- ReqLast  out  1  current line is the last line of the batch
- RdDout  out  RBB_DATA_WIDTH  line data
- ReqAck  in  1  requester consumed the current line
- Empty  out  1  no committed bank

## Operation
- Registers: wr_ptr, rd_ptr (BANK_W, wrap mod NUM_BANKS), cnt (0..NUM_BANKS), len[NUM_BANKS] (RBB_ADDR_WIDTH+1), line counter idx.
- Full = (cnt==NUM_BANKS); Empty = (cnt==0); WrBank = wr_ptr.
- Write: RAM address {wr_ptr, WrAddr}. WrEn while Full is dropped and sets Overflow.
- Commit: task_done && !Full → len[wr_ptr] = min(task_len, 2^RBB_ADDR_WIDTH), wr_ptr+1, cnt+1. task_done while Full is ignored and sets Overflow. task_len==0 is ignored: no commit, no error.
- WrEn and task_done in the same cycle: the line is written to the bank being committed.
- Drain state machine:
  - IDLE: if cnt≠0, raddr={rd_ptr,0} → PREFETCH.
  - PREFETCH: 1 cycle → VALID.
  - VALID: ReqValid=1. ReqLast = (idx==len[rd_ptr]-1). Without ReqAck, raddr holds and outputs stay stable.
  - VALID with ReqAck and not last: idx+1, raddr=idx+1, stay VALID.
  - VALID with ReqAck and last: release the bank (rd_ptr+1, cnt-1, idx=0). If another bank was committed before this cycle (cnt>1), raddr={rd_ptr+1,0} and stay VALID with no bubble; else → IDLE.
- Commit and release in the same cycle: cnt unchanged, both pointers advance.
- ReqAck outside VALID is ignored.
- ReqBank = rd_ptr; ReqLineIdx = idx.

## Timing
- Reset values: ReqValid=0, ReqLast=0, ReqBank=0, ReqLineIdx=0, RdDout=0, WrBank=0, Full=0, Overflow=0, Empty=1.
- Reset mid-drain discards all batches and pointers. RAM contents are not cleared.
- RAM read latency is 1 cycle (registered). RdDout is the RAM output.
- First ReqValid comes 2 cycles after the task_done edge (commit → IDLE sees cnt≠0 → PREFETCH → VALID).
- Throughput is 1 line/cycle with ReqAck held high, including across bank boundaries when the next bank is already committed.
- A freed bank is writable the cycle after the final ReqAck. Full deasserts the same cycle.

## Structure
- Package rbb_pkg: drain state encoding (IDLE/PREFETCH/VALID), clog2 function, BANK_W derivation.
- Sub-module: existing nlb_gram_sdp, depth NUM_BANKS·2^RBB_ADDR_WIDTH, address {bank,line}, GRAM_MODE 1. The control logic stays flat in rbb_pp.

## Test plan
- Single batch, RBB_ADDR_WIDTH=4, task_len=5, ReqAck high → 5 consecutive ReqValid beats, lines 0..4 data match, ReqLast on line 4, then Empty=1.
- Back-to-back: commit bank0 (len 3) and bank1 (len 2) before the drain starts → 5 gapless beats, ReqBank 0,0,0,1,1.
- Backpressure: ReqAck toggled 1-0-1 → RdDout and ReqLineIdx stable while ReqAck=0, no line skipped or repeated.
- Full with NUM_BANKS=2: commit twice with no ack → Full=1. A third task_done or WrEn sets Overflow and buffered data stays intact.
- Simultaneous events: task_done in the same cycle as the final ReqAck → cnt unchanged, no lost batch. task_len=20 with width 4 clamps to 16 lines.
- Reset asserted mid-drain at line 2 → next cycle ReqValid=0, Empty=1, Overflow=0.

Source files
------------

// File: rtl/rbb_pkg.sv
// rbb_pp shared definitions: drain FSM encoding and width helpers.
package rbb_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREFETCH = 2'd1;
    localparam logic [1:0] ST_VALID    = 2'd2;

    function automatic int rbb_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int rbb_bank_w(input int nb);
        return (nb < 2) ? 1 : rbb_clog2(nb);
    endfunction

endpackage

// File: rtl/rbb_pp_if.sv
// Fill/drain bundle between PE array, rbb_pp and the write-request path.
interface rbb_pp_if
    import rbb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 512,
    parameter int BW = rbb_bank_w(2)
) ();

    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [DW-1:0] WrDin;
    logic          task_done;
    logic [AW:0]   task_len;
    logic [BW-1:0] WrBank;
    logic          Full;
    logic          Overflow;
    logic          ReqValid;
    logic [BW-1:0] ReqBank;
    logic [AW-1:0] ReqLineIdx;
    logic          ReqLast;
    logic [DW-1:0] RdDout;
    logic          ReqAck;
    logic          Empty;

    modport master (
        output WrEn, WrAddr, WrDin, task_done, task_len, ReqAck,
        input  WrBank, Full, Overflow, ReqValid, ReqBank,
        input  ReqLineIdx, ReqLast, RdDout, Empty
    );

    modport slave (
        input  WrEn, WrAddr, WrDin, task_done, task_len, ReqAck,
        output WrBank, Full, Overflow, ReqValid, ReqBank,
        output ReqLineIdx, ReqLast, RdDout, Empty
    );

endinterface

// File: rtl/nlb_gram_sdp.sv
// Simple dual-port RAM, one write and one read port.
// GRAM_MODE 1: registered read (1 cycle); GRAM_MODE 2: extra output register.
module nlb_gram_sdp #(
    parameter int BUS_SIZE_ADDR = 4,
    parameter int BUS_SIZE_DATA = 32,
    parameter int GRAM_MODE     = 1
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [BUS_SIZE_ADDR-1:0] i_waddr,
    input  logic [BUS_SIZE_DATA-1:0] i_din,
    input  logic [BUS_SIZE_ADDR-1:0] i_raddr,
    output logic [BUS_SIZE_DATA-1:0] o_dout
);

    logic [BUS_SIZE_DATA-1:0] r_mem [0:(1 << BUS_SIZE_ADDR)-1];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_din;
    end

    generate
        if (GRAM_MODE == 2) begin : g_two
            logic [BUS_SIZE_DATA-1:0] r_q;
            always_ff @(posedge clk) begin
                r_q    <= r_mem[i_raddr];
                o_dout <= r_q;
            end
        end else begin : g_one
            always_ff @(posedge clk) begin
                o_dout <= r_mem[i_raddr];
            end
        end
    endgenerate

endmodule

// File: rtl/rbb_pp.sv
// Multi-bank result batch buffer: PE array fills one bank while
// committed banks drain line by line to the write-request path.
module rbb_pp
    import rbb_pkg::*;
#(
    parameter int RBB_ADDR_WIDTH = 8,
    parameter int RBB_DATA_WIDTH = 512,
    parameter int NUM_BANKS      = 2
) (
    input  logic    clk,
    input  logic    reset,
    rbb_pp_if.slave bus
);

    localparam int BANK_W = rbb_bank_w(NUM_BANKS);
    localparam int LW     = RBB_ADDR_WIDTH + 1;
    localparam int RAW    = BANK_W + RBB_ADDR_WIDTH;
    localparam int CW     = BANK_W + 1;
    localparam logic [LW-1:0] MAX_LEN = {1'b1, {RBB_ADDR_WIDTH{1'b0}}};
    localparam logic [RBB_ADDR_WIDTH-1:0] LINE0 = '0;

    logic [1:0]                r_state;
    logic [1:0]                w_state;
    logic [RAW-1:0]            r_raddr;
    logic [RAW-1:0]            w_raddr;
    logic [BANK_W-1:0]         r_wr_ptr;
    logic [BANK_W-1:0]         r_rd_ptr;
    logic [BANK_W-1:0]         w_rd_nxt;
    logic [CW-1:0]             r_cnt;
    logic [LW-1:0]             r_len [NUM_BANKS];
    logic [RBB_ADDR_WIDTH-1:0] r_idx;
    logic [RBB_ADDR_WIDTH-1:0] w_idx_nxt;
    logic                      r_ovf;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_commit;
    logic                      w_we;
    logic [LW-1:0]             w_len_cl;
    logic                      w_valid;
    logic                      w_last;
    logic                      w_rel;
    logic                      w_adv;
    logic [RBB_DATA_WIDTH-1:0] w_dout;

    assign w_full    = (r_cnt == CW'(NUM_BANKS));
    assign w_empty   = (r_cnt == '0);
    assign w_we      = bus.WrEn && !w_full;
    assign w_commit  = bus.task_done && !w_full && (bus.task_len != '0);
    assign w_len_cl  = (bus.task_len > MAX_LEN) ? MAX_LEN : bus.task_len;
    assign w_valid   = (r_state == ST_VALID);
    assign w_last    = ({1'b0, r_idx} == (r_len[r_rd_ptr] - LW'(1)));
    assign w_rel     = w_valid && bus.ReqAck && w_last;
    assign w_adv     = w_valid && bus.ReqAck && !w_last;
    assign w_rd_nxt  = r_rd_ptr + 1'b1;
    assign w_idx_nxt = r_idx + 1'b1;

    // The RAM samples the next read address so data lines up with idx.
    always_comb begin
        w_state = r_state;
        w_raddr = r_raddr;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_raddr = {r_rd_ptr, LINE0};
                    w_state = ST_PREFETCH;
                end
            end
            ST_PREFETCH: w_state = ST_VALID;
            ST_VALID: begin
                if (w_adv) begin
                    w_raddr = {r_rd_ptr, w_idx_nxt};
                end else if (w_rel) begin
                    if (r_cnt > CW'(1)) w_raddr = {w_rd_nxt, LINE0};
                    else                w_state = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_raddr  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_raddr <= w_raddr;
            if (w_commit) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rel) begin
                r_rd_ptr <= w_rd_nxt;
                r_idx    <= '0;
            end else if (w_adv) begin
                r_idx <= w_idx_nxt;
            end
            case ({w_commit, w_rel})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if ((bus.WrEn || bus.task_done) && w_full) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANKS; i++) r_len[i] <= '0;
        end else if (w_commit) begin
            r_len[r_wr_ptr] <= w_len_cl;
        end
    end

    nlb_gram_sdp #(
        .BUS_SIZE_ADDR (RAW),
        .BUS_SIZE_DATA (RBB_DATA_WIDTH),
        .GRAM_MODE     (1)
    ) u_gram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr ({r_wr_ptr, bus.WrAddr}),
        .i_din   (bus.WrDin),
        .i_raddr (w_raddr),
        .o_dout  (w_dout)
    );

    assign bus.WrBank     = r_wr_ptr;
    assign bus.Full       = w_full;
    assign bus.Empty      = w_empty;
    assign bus.Overflow   = r_ovf;
    assign bus.ReqValid   = w_valid;
    assign bus.ReqBank    = r_rd_ptr;
    assign bus.ReqLineIdx = r_idx;
    assign bus.ReqLast    = w_valid && w_last;
    assign bus.RdDout     = w_valid ? w_dout : '0;

endmodule
